// File: rtl/mem_access_pkg.sv
// Shared types and default widths for the memory access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 16;

endpackage

// File: rtl/data_register.sv
// Loadable register with synchronous active-high clear, used for MAR and MDR.
module data_register
  import mem_access_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wait_timer.sv
// Counts request cycles without ack; expired flags the last permitted cycle.
module wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LastVal = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CntW-1:0] Last = CntW'(LastVal);

  logic [CntW-1:0] cnt;

  // Saturates instead of wrapping so a disabled timeout never aliases.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CntW{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == Last);

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR pair with a single req/ack memory access, wait states and optional timeout.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_mar,
  input  logic [ADDR_W-1:0] mar_in,
  input  logic              ld_mdr,
  input  logic [DATA_W-1:0] mdr_in,
  input  logic              start,
  input  logic              we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_t            state;
  logic              mar_ld;
  logic              mdr_ld;
  logic [DATA_W-1:0] mdr_d;
  logic              tmr_clr;
  logic              tmr_en;
  logic              expired;

  // Bus loads only in IDLE; read data only lands on an ack in REQ.
  always_comb begin
    mar_ld = 1'b0;
    mdr_ld = 1'b0;
    mdr_d  = mdr_in;
    if (state == IDLE) begin
      mar_ld = ld_mar;
      mdr_ld = ld_mdr;
    end else if (state == REQ) begin
      mdr_ld = mem_ack && !mem_we;
      mdr_d  = mem_rdata;
    end
  end

  data_register #(
    .WIDTH(ADDR_W)
  ) u_mar (
    .clk  (clk),
    .reset(reset),
    .ld   (mar_ld),
    .d    (mar_in),
    .q    (mar_out)
  );

  data_register #(
    .WIDTH(DATA_W)
  ) u_mdr (
    .clk  (clk),
    .reset(reset),
    .ld   (mdr_ld),
    .d    (mdr_d),
    .q    (mdr_out)
  );

  assign tmr_clr = (state == DONE);
  assign tmr_en  = (state == REQ) && !mem_ack;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(expired)
  );

  assign mem_addr  = mar_out;
  assign mem_wdata = mdr_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= REQ;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            mem_we  <= we;
            err     <= 1'b0;
          end
        end
        REQ: begin
          // Ack takes priority over a coincident timeout.
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b0;
          end else if (expired) begin
            state   <= DONE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: default instance plus a 32-bit, no-timeout instance.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default instance (DATA_W=16, ADDR_W=16, TIMEOUT=15)
  logic        ld_mar, ld_mdr, start, we, mem_ack;
  logic [15:0] mar_in, mdr_in, mem_rdata;
  logic        busy, done, err, mem_we, mem_req;
  logic [15:0] mar_out, mdr_out, mem_addr, mem_wdata;

  // Wide instance (DATA_W=32, TIMEOUT=0)
  logic        ld_mar2, ld_mdr2, start2, we2, mem_ack2;
  logic [15:0] mar_in2;
  logic [31:0] mdr_in2, mem_rdata2;
  logic        busy2, done2, err2, mem_we2, mem_req2;
  logic [15:0] mar_out2, mem_addr2;
  logic [31:0] mdr_out2, mem_wdata2;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  mem_access_unit dut (
    .clk      (clk),
    .reset    (reset),
    .ld_mar   (ld_mar),
    .mar_in   (mar_in),
    .ld_mdr   (ld_mdr),
    .mdr_in   (mdr_in),
    .start    (start),
    .we       (we),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mar_out  (mar_out),
    .mdr_out  (mdr_out),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_req  (mem_req),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  mem_access_unit #(
    .DATA_W (32),
    .ADDR_W (16),
    .TIMEOUT(0)
  ) dut2 (
    .clk      (clk),
    .reset    (reset),
    .ld_mar   (ld_mar2),
    .mar_in   (mar_in2),
    .ld_mdr   (ld_mdr2),
    .mdr_in   (mdr_in2),
    .start    (start2),
    .we       (we2),
    .busy     (busy2),
    .done     (done2),
    .err      (err2),
    .mar_out  (mar_out2),
    .mdr_out  (mdr_out2),
    .mem_addr (mem_addr2),
    .mem_wdata(mem_wdata2),
    .mem_we   (mem_we2),
    .mem_req  (mem_req2),
    .mem_rdata(mem_rdata2),
    .mem_ack  (mem_ack2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    n_checks++;
    if ({mem_req, busy, done, err, mem_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, busy, done, err, mem_we});
    end
    n_checks++;
    if ({mar_out, mdr_out} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h expected 00000000", {mar_out, mdr_out});
    end
    n_checks++;
    if ({mem_req2, done2, mdr_out2} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_wide: got %h expected 0", {mem_req2, done2, mdr_out2});
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_read_zero_wait();
    ld_mar = 1'b1; mar_in = 16'h3000;
    cyc();
    ld_mar = 1'b0;
    start = 1'b1; we = 1'b0;
    cyc();
    start = 1'b0;
    n_checks++;
    if ({mem_req, busy, mem_we, mem_addr} !== {3'b110, 16'h3000}) begin
      n_fail++;
      $display("FAIL rd0_req: got %h expected %h", {mem_req, busy, mem_we, mem_addr},
               {3'b110, 16'h3000});
    end
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    cyc();
    mem_ack = 1'b0;
    n_checks++;
    if ({done, err, mem_req, mdr_out} !== {3'b100, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL rd0_done: got %h expected %h", {done, err, mem_req, mdr_out},
               {3'b100, 16'hBEEF});
    end
    cyc();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL rd0_pulse: got done=%b expected 0", done);
    end
  endtask

  task automatic test_write_wait3();
    ld_mar = 1'b1; mar_in = 16'h1234;
    ld_mdr = 1'b1; mdr_in = 16'h00FF;
    cyc();
    ld_mar = 1'b0; ld_mdr = 1'b0;
    start = 1'b1; we = 1'b1;
    cyc();
    start = 1'b0; we = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if ({mem_req, mem_we, done, mem_addr, mem_wdata} !== {3'b110, 16'h1234, 16'h00FF}) begin
        n_fail++;
        $display("FAIL wr3_req%0d: got %h expected %h", i,
                 {mem_req, mem_we, done, mem_addr, mem_wdata}, {3'b110, 16'h1234, 16'h00FF});
      end
      if (i == 4) begin
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      end
      cyc();
    end
    mem_ack = 1'b0;
    n_checks++;
    if ({done, err, mem_req, mdr_out} !== {3'b100, 16'h00FF}) begin
      n_fail++;
      $display("FAIL wr3_done: got %h expected %h", {done, err, mem_req, mdr_out},
               {3'b100, 16'h00FF});
    end
    cyc();
  endtask

  task automatic test_timeout();
    start = 1'b1; we = 1'b0;
    cyc();
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (mem_req) cnt++;
      cyc();
    end
    n_checks++;
    if (cnt !== 15) begin
      n_fail++;
      $display("FAIL to_req_cycles: got %0d expected 15", cnt);
    end
    n_checks++;
    if ({done, err, mdr_out} !== {2'b11, 16'h00FF}) begin
      n_fail++;
      $display("FAIL to_done: got %h expected %h", {done, err, mdr_out}, {2'b11, 16'h00FF});
    end
    cyc();
    n_checks++;
    if ({done, err} !== 2'b01) begin
      n_fail++;
      $display("FAIL to_err_hold: got %b expected 01", {done, err});
    end
    // Next start clears err; this access then hits the ack/timeout collision.
    start = 1'b1; we = 1'b0;
    cyc();
    start = 1'b0;
    n_checks++;
    if ({err, mem_req} !== 2'b01) begin
      n_fail++;
      $display("FAIL to_err_clear: got %b expected 01", {err, mem_req});
    end
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) begin
        mem_ack = 1'b1; mem_rdata = 16'h0A0A;
      end
      cyc();
    end
    mem_ack = 1'b0;
    n_checks++;
    if ({done, err, mdr_out} !== {2'b10, 16'h0A0A}) begin
      n_fail++;
      $display("FAIL collide: got %h expected %h", {done, err, mdr_out}, {2'b10, 16'h0A0A});
    end
    cyc();
  endtask

  task automatic test_ignored();
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    cyc();
    cyc();
    mem_ack = 1'b0;
    n_checks++;
    if ({done, mem_req, mdr_out} !== {2'b00, 16'h0A0A}) begin
      n_fail++;
      $display("FAIL idle_ack: got %h expected %h", {done, mem_req, mdr_out}, {2'b00, 16'h0A0A});
    end
    start = 1'b1; we = 1'b0;
    cyc();
    start = 1'b1;
    ld_mar = 1'b1; mar_in = 16'hFFFF;
    ld_mdr = 1'b1; mdr_in = 16'h7777;
    cyc();
    start = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0;
    n_checks++;
    if ({mem_req, mar_out, mdr_out} !== {1'b1, 16'h1234, 16'h0A0A}) begin
      n_fail++;
      $display("FAIL req_loads: got %h expected %h", {mem_req, mar_out, mdr_out},
               {1'b1, 16'h1234, 16'h0A0A});
    end
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    cyc();
    mem_ack = 1'b0;
    n_checks++;
    if ({done, mdr_out} !== {1'b1, 16'h1111}) begin
      n_fail++;
      $display("FAIL ign_done: got %h expected %h", {done, mdr_out}, {1'b1, 16'h1111});
    end
    cyc();
    cyc();
    n_checks++;
    if ({done, mem_req, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL no_extra: got %b expected 000", {done, mem_req, busy});
    end
  endtask

  task automatic test_reset_mid();
    ld_mar = 1'b1; mar_in = 16'h4000;
    ld_mdr = 1'b1; mdr_in = 16'h2222;
    cyc();
    ld_mar = 1'b0; ld_mdr = 1'b0;
    start = 1'b1; we = 1'b1;
    cyc();
    start = 1'b0; we = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_checks++;
    if ({mem_req, busy, done, mar_out, mdr_out} !== 35'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got %h expected 0", {mem_req, busy, done, mar_out, mdr_out});
    end
    cyc();
    n_checks++;
    if ({done, mem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_nodone: got %b expected 00", {done, mem_req});
    end
    ld_mar = 1'b1; mar_in = 16'h3000;
    cyc();
    ld_mar = 1'b0;
    start = 1'b1; we = 1'b0;
    cyc();
    start = 1'b0;
    cyc();
    mem_ack = 1'b1; mem_rdata = 16'h1357;
    cyc();
    mem_ack = 1'b0;
    n_checks++;
    if ({done, err, mdr_out} !== {2'b10, 16'h1357}) begin
      n_fail++;
      $display("FAIL rst_fresh: got %h expected %h", {done, err, mdr_out}, {2'b10, 16'h1357});
    end
    cyc();
  endtask

  task automatic test_no_timeout_wide();
    ld_mar2 = 1'b1; mar_in2 = 16'hA0A0;
    cyc();
    ld_mar2 = 1'b0;
    start2 = 1'b1; we2 = 1'b0;
    cyc();
    start2 = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 100 && !done2; i++) begin
      if (mem_req2) cnt++;
      if (i == 100) begin
        mem_ack2 = 1'b1; mem_rdata2 = 32'hDEADBEEF;
      end
      cyc();
    end
    mem_ack2 = 1'b0;
    n_checks++;
    if (cnt !== 100) begin
      n_fail++;
      $display("FAIL wide_req_cycles: got %0d expected 100", cnt);
    end
    n_checks++;
    if ({done2, err2, mdr_out2} !== {2'b10, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL wide_done: got %h expected %h", {done2, err2, mdr_out2},
               {2'b10, 32'hDEADBEEF});
    end
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    ld_mar = 1'b0; ld_mdr = 1'b0; start = 1'b0; we = 1'b0; mem_ack = 1'b0;
    mar_in = '0; mdr_in = '0; mem_rdata = '0;
    ld_mar2 = 1'b0; ld_mdr2 = 1'b0; start2 = 1'b0; we2 = 1'b0; mem_ack2 = 1'b0;
    mar_in2 = '0; mdr_in2 = '0; mem_rdata2 = '0;
    test_reset();
    test_read_zero_wait();
    test_write_wait3();
    test_timeout();
    test_ignored();
    test_reset_mid();
    test_no_timeout_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the datapath's fixed 16-bit MAR/MDR pair.
- Holds an address register (MAR) and a data register (MDR), and runs a single memory read or write over a req/ack handshake.
- Supports variable wait states, an optional timeout with error flag, and a one-cycle done pulse.
- Sits between the datapath bus and the memory/IO subsystem; the control FSM drives ld/start and waits for done.

Parameters:
- DATA_W, 16, width of MDR and memory data buses.
- ADDR_W, 16, width of MAR and memory address bus.
- TIMEOUT, 15, max REQ-state cycles without ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_mar  in  1  load MAR from mar_in (honoured only in IDLE).
- mar_in  in  ADDR_W  address from CPU bus.
- ld_mdr  in  1  load MDR from mdr_in (honoured only in IDLE).
- mdr_in  in  DATA_W  data from CPU bus.
- start  in  1  begin access (honoured only in IDLE).
- we  in  1  access type sampled with start: 1=write, 0=read.
- busy  out  1  high while in REQ.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  valid with done: 1 = timed out.
- mar_out  out  ADDR_W  MAR contents.
- mdr_out  out  DATA_W  MDR contents.
- mem_addr  out  ADDR_W  equals MAR.
- mem_wdata  out  DATA_W  equals MDR.
- mem_we  out  1  registered access type, valid while mem_req is high.
- mem_req  out  1  registered request.
- mem_rdata  in  DATA_W  read data, valid when mem_ack is high.
- mem_ack  in  1  access complete; sampled only while mem_req is high.

Behaviour:
- Reset values: MAR=0, MDR=0, state=IDLE, mem_req=0, mem_we=0, busy=0, done=0, err=0, timer=0.
- States: IDLE, REQ, DONE.
- IDLE:
  - ld_mar/ld_mdr load on the edge.
  - If ld_mdr and start occur together, the new MDR value is written.
  - On start, latch we, go to REQ. mem_req=1 from the next cycle.
- REQ:
  - busy=1. Loads and start are ignored.
  - On an edge with mem_ack=1: for a read, MDR<=mem_rdata; for a write, MDR is unchanged. Then err<=0, go to DONE, mem_req<=0.
  - Else, if TIMEOUT!=0 and timer==TIMEOUT-1: err<=1, MDR unchanged, go to DONE, mem_req<=0.
  - Else timer increments.
  - If ack and timeout coincide, ack wins (err=0).
- DONE:
  - done=1 for exactly one cycle. err holds its value.
  - Next state is IDLE. The timer clears.
  - start in DONE is ignored.
- err is held until the next start is accepted, then cleared.
- Latency: start at edge 0 → mem_req high in cycles 1..k, where ack is seen at edge k. done is high in cycle k+1. Minimum start→done is 2 cycles (ack in the first REQ cycle).
- Timeout: with no ack, mem_req is high for exactly TIMEOUT cycles, then done+err.
- mem_ack outside REQ is ignored. No spurious MDR update.
- Reset mid-operation: next state is IDLE, and mem_req drops at that edge. MAR/MDR clear, and no done pulse occurs.
- Timer width is $clog2(TIMEOUT+1), minimum 1 bit. The timer never wraps.

Decomposition:
- Shared package mem_access_pkg holds:
  - the state typedef enum logic [1:0] {IDLE, REQ, DONE};
  - default width constants DATA_W_DEF=16 and ADDR_W_DEF=16.
- One natural sub-module, wait_timer:
  - parametrised by TIMEOUT;
  - inputs clk, reset, clr, en;
  - output expired, which is tied low when TIMEOUT==0.
- MAR/MDR reuse the existing register module with its width parameter.

Test Plan:
- Read, zero wait: ld_mar 0x3000, start we=0, memory acks in the first REQ cycle with rdata 0xBEEF → mem_req high 1 cycle, done in cycle 2, err=0, mdr_out=0xBEEF.
- Write, 3 wait states: MAR=0x1234, MDR=0x00FF, start we=1, ack on the 4th REQ cycle → mem_we=1 and mem_wdata=0x00FF throughout, done at cycle 5, MDR still 0x00FF.
- Timeout: TIMEOUT=15, read with ack never asserted → mem_req high exactly 15 cycles, done+err=1, MDR unchanged; the next start clears err.
- Ack/timeout collision: ack on the 15th REQ cycle with rdata 0x0A0A → err=0, MDR=0x0A0A.
- Ignored inputs: during REQ, pulse ld_mar 0xFFFF, ld_mdr, start; assert mem_ack in IDLE → MAR/MDR unchanged, no extra access, no done.
- Reset mid-access: reset in the 2nd REQ cycle → next cycle mem_req=0, busy=0, done=0, MAR=MDR=0; a fresh read then completes normally. Repeat with DATA_W=32, TIMEOUT=0: an ack after 100 cycles still completes without err.
